// File: rtl/spi_master.sv
// spi_master: SPI mode-0 (CPOL=0, CPHA=0) master issuing 24-bit MSB-first frames.
// sclk, cs_n and mosi come from clk_sb through a divider; miso is captured into a 24-bit word.
// Optional burst mode is built when SPI_MASTER_BURST_EN is defined. It adds a hold_cs input that
// keeps cs_n low between frames.
module spi_master #(
    parameter int CLK_DIV  = 8,
    parameter int CS_SETUP = 4,
    parameter int CS_GAP   = 8
) (
    input  logic        clk_sb,
    input  logic        reset_n,
    input  logic        start,
    input  logic [23:0] tx_data,
`ifdef SPI_MASTER_BURST_EN
    input  logic        hold_cs,
`endif
    output logic        busy,
    output logic        done,
    output logic [23:0] rx_data,
    output logic        sclk,
    output logic        cs_n,
    output logic        mosi,
    input  logic        miso
);

    // One shared cycle counter serves the divider, the cs setup time and the gap time.
    // It is sized for the longest of the three.
    localparam int CNT_SPAN = (CLK_DIV > CS_SETUP) ? ((CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP)
                                                   : ((CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP);
    localparam int CNT_W = $clog2(CNT_SPAN) + 1;

    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(CS_GAP - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETUP   = 3'd1;
    localparam logic [2:0] ST_XFER    = 3'd2;
    localparam logic [2:0] ST_HOLD    = 3'd3;
    localparam logic [2:0] ST_GAP     = 3'd4;
`ifdef SPI_MASTER_BURST_EN
    localparam logic [2:0] ST_IDLE_CS = 3'd5;
`endif

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       bit_cnt_q, bit_cnt_d;
    logic [23:0]      tx_shift_q, tx_shift_d;
    logic [23:0]      rx_shift_q, rx_shift_d;
    logic [23:0]      rx_data_q, rx_data_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             sclk_q, sclk_d;
    logic             cs_n_q, cs_n_d;
    logic             mosi_q, mosi_d;
    logic             miso_s1_q, miso_s2_q;
`ifdef SPI_MASTER_BURST_EN
    logic             hold_q, hold_d;
`endif
    logic             accept;
    logic             sclk_rise;

    // Next-state logic: frame sequencing, divider, bit shifting and result capture.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_cnt_d  = bit_cnt_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        sclk_d     = sclk_q;
        cs_n_d     = cs_n_q;
        mosi_d     = mosi_q;
`ifdef SPI_MASTER_BURST_EN
        hold_d     = hold_q;
        accept     = start && ((state_q == ST_IDLE) || (state_q == ST_IDLE_CS));
`else
        accept     = start && (state_q == ST_IDLE);
`endif
        sclk_rise  = 1'b0;

        case (state_q)
            ST_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    cnt_d     = '0;
                    sclk_d    = 1'b1;
                    sclk_rise = 1'b1;
                    state_d   = ST_XFER;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_XFER: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d = '0;
                    if (sclk_q) begin
                        // Falling edge: a bit is complete. Present the next bit or finish.
                        sclk_d    = 1'b0;
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd23) begin
                            state_d = ST_HOLD;
                        end else begin
                            tx_shift_d = tx_shift_q << 1;
                            mosi_d     = tx_shift_q[22];
                        end
                    end else begin
                        sclk_d    = 1'b1;
                        sclk_rise = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_HOLD: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d     = '0;
                    rx_data_d = rx_shift_q;
                    done_d    = 1'b1;
                    mosi_d    = 1'b0;
`ifdef SPI_MASTER_BURST_EN
                    if (hold_q) begin
                        busy_d  = 1'b0;
                        state_d = ST_IDLE_CS;
                    end else begin
                        cs_n_d  = 1'b1;
                        state_d = ST_GAP;
                    end
`else
                    cs_n_d  = 1'b1;
                    state_d = ST_GAP;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                // IDLE (and IDLE-CS in burst builds): accept handled below.
            end
        endcase

        // The synchronised miso sample lands 2 cycles before each sclk rise.
        // Mosi was set at the previous fall, so the data is already stable by then.
        if (sclk_rise) begin
            rx_shift_d = {rx_shift_q[22:0], miso_s2_q};
        end

        if (accept) begin
            tx_shift_d = tx_data;
            mosi_d     = tx_data[23];
            rx_shift_d = '0;
            bit_cnt_d  = '0;
            cnt_d      = '0;
            busy_d     = 1'b1;
            cs_n_d     = 1'b0;
            state_d    = ST_SETUP;
`ifdef SPI_MASTER_BURST_EN
            hold_d     = hold_cs;
`endif
        end
    end

    // State registers. Reset forces cs_n high immediately and discards any partial frame.
    always_ff @(posedge clk_sb or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_cnt_q  <= '0;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sclk_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
            miso_s1_q  <= 1'b0;
            miso_s2_q  <= 1'b0;
`ifdef SPI_MASTER_BURST_EN
            hold_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            sclk_q     <= sclk_d;
            cs_n_q     <= cs_n_d;
            mosi_q     <= mosi_d;
            miso_s1_q  <= miso;
            miso_s2_q  <= miso_s1_q;
`ifdef SPI_MASTER_BURST_EN
            hold_q     <= hold_d;
`endif
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_data = rx_data_q;
    assign sclk    = sclk_q;
    assign cs_n    = cs_n_q;
    assign mosi    = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: self-checking bench for spi_master with default parameters.
// A behavioural SPI slave drives miso and records mosi. Frames use either that slave or a mosi->miso loopback.
module tb_spi_master;

    localparam int CLK_DIV   = 8;
    localparam int CS_SETUP  = 4;
    localparam int CS_GAP    = 8;
    localparam int FRAME_LAT = 1 + CS_SETUP + 47 * CLK_DIV + CLK_DIV;

    logic        clk_sb  = 1'b0;
    logic        reset_n = 1'b0;
    logic        start   = 1'b0;
    logic [23:0] tx_data = '0;
`ifdef SPI_MASTER_BURST_EN
    logic        hold_cs = 1'b0;
`endif
    logic        busy, done, sclk, cs_n, mosi, miso;
    logic [23:0] rx_data;

    // Slave model state
    logic        loop_en    = 1'b1;
    logic        slave_miso = 1'b0;
    logic [23:0] slave_word = '0;
    logic [23:0] slave_sh   = '0;
    logic [23:0] slave_cap  = '0;
    int          rise_cnt   = 0;
    logic        sclk_prev  = 1'b0;
    logic        cs_prev    = 1'b1;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [23:0] prev_rx  = '0;

    typedef struct {
        logic [23:0] tx;
        logic [23:0] sw;
        logic        lp;
        logic [23:0] exp_rx;
    } vec_t;
    vec_t vecs[6];

    assign miso = loop_en ? mosi : slave_miso;

    always #5 clk_sb = ~clk_sb;

    spi_master #(.CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_GAP(CS_GAP)) dut (
        .clk_sb (clk_sb),
        .reset_n(reset_n),
        .start  (start),
        .tx_data(tx_data),
`ifdef SPI_MASTER_BURST_EN
        .hold_cs(hold_cs),
`endif
        .busy   (busy),
        .done   (done),
        .rx_data(rx_data),
        .sclk   (sclk),
        .cs_n   (cs_n),
        .mosi   (mosi),
        .miso   (miso)
    );

    // Mode-0 slave: the first bit is presented at the cs_n fall and each next bit at an sclk fall.
    // Mosi is recorded at every sclk rise.
    always @(sclk or cs_n) begin
        if (cs_prev === 1'b1 && cs_n === 1'b0) begin
            rise_cnt   = 0;
            slave_cap  = '0;
            slave_sh   = slave_word;
            slave_miso = slave_word[23];
        end
        if (cs_n === 1'b0 && sclk_prev === 1'b0 && sclk === 1'b1) begin
            slave_cap = {slave_cap[22:0], mosi};
            rise_cnt++;
        end
        if (cs_n === 1'b0 && sclk_prev === 1'b1 && sclk === 1'b0) begin
            slave_sh   = slave_sh << 1;
            slave_miso = slave_sh[23];
        end
        sclk_prev = sclk;
        cs_prev   = cs_n;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, got, exp);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 1000) begin
            @(negedge clk_sb);
            n++;
        end
        chk("idle wait busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk_sb);
    endtask

    task automatic run_frame(input logic [23:0] tx, input logic [23:0] sw, input logic lp,
                             input logic [23:0] exp_rx, input string tag);
        int lat = 0;
        bit seen = 0;
        wait_idle();
        @(negedge clk_sb);
        loop_en    = lp;
        slave_word = sw;
        tx_data    = tx;
        start      = 1'b1;
        while (!seen && lat < 2000) begin
            @(negedge clk_sb);
            lat++;
            if (lat == 1) begin
                start   = 1'b0;
                tx_data = $urandom;
                chk({tag, " busy"}, {31'd0, busy}, 32'd1);
            end
            if (lat == 200) chk({tag, " rx hold"}, {8'd0, rx_data}, {8'd0, prev_rx});
            if (done === 1'b1) seen = 1;
        end
        chk({tag, " latency"}, lat, FRAME_LAT);
        chk({tag, " rx_data"}, {8'd0, rx_data}, {8'd0, exp_rx});
        chk({tag, " mosi seen"}, {8'd0, slave_cap}, {8'd0, tx});
        chk({tag, " rises"}, rise_cnt, 24);
        chk({tag, " cs_n at done"}, {31'd0, cs_n}, 32'd1);
        @(negedge clk_sb);
        chk({tag, " done width"}, {31'd0, done}, 32'd0);
        chk({tag, " mosi gap"}, {31'd0, mosi}, 32'd0);
        prev_rx = exp_rx;
        $display("frame %s tx=%06h rx=%06h lat=%0d", tag, tx, rx_data, lat);
    endtask

    initial begin
        int n, dones, falls, gap_len, bad;
        logic pcs;

        vecs[0] = '{24'hA5C3F0, 24'h000000, 1'b1, 24'hA5C3F0};
        vecs[1] = '{24'hFF00AA, 24'h123456, 1'b0, 24'h123456};
        vecs[2] = '{24'h000000, 24'hFFFFFF, 1'b0, 24'hFFFFFF};
        vecs[3] = '{24'hFFFFFF, 24'h000000, 1'b0, 24'h000000};
        vecs[4] = '{24'h800001, 24'h000000, 1'b1, 24'h800001};
        vecs[5] = '{24'h5A5A5A, 24'hC00003, 1'b0, 24'hC00003};

        // Reset state
        repeat (3) @(negedge clk_sb);
        chk("rst cs_n", {31'd0, cs_n}, 32'd1);
        chk("rst sclk", {31'd0, sclk}, 32'd0);
        chk("rst mosi", {31'd0, mosi}, 32'd0);
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst done", {31'd0, done}, 32'd0);
        chk("rst rx_data", {8'd0, rx_data}, 32'd0);
        reset_n = 1'b1;

        // Idle 100 cycles with start low
        bad = 0;
        dones = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_sb);
            if (done === 1'b1) dones++;
            if (cs_n !== 1'b1 || sclk !== 1'b0 || mosi !== 1'b0 || busy !== 1'b0) bad++;
        end
        chk("idle pin errors", bad, 0);
        chk("idle done pulses", dones, 0);
        $display("idle 100 cycles done_pulses=%0d", dones);

        // Reset asserted at bit 10 of a loopback frame
        @(negedge clk_sb);
        loop_en = 1'b1;
        tx_data = 24'h5A5A5A;
        start   = 1'b1;
        @(negedge clk_sb);
        start = 1'b0;
        n = 0;
        while (rise_cnt < 10 && n < 1000) begin
            @(negedge clk_sb);
            n++;
        end
        chk("midrst reached bit 10", rise_cnt, 10);
        #1 reset_n = 1'b0;
        #1;
        chk("midrst cs_n", {31'd0, cs_n}, 32'd1);
        chk("midrst sclk", {31'd0, sclk}, 32'd0);
        chk("midrst busy", {31'd0, busy}, 32'd0);
        chk("midrst rx_data", {8'd0, rx_data}, {8'd0, prev_rx});
        repeat (3) @(negedge clk_sb);
        reset_n = 1'b1;
        dones = 0;
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_sb);
            if (done === 1'b1) dones++;
            if (cs_n !== 1'b1) bad++;
        end
        chk("midrst no done", dones, 0);
        chk("midrst cs_n stays high", bad, 0);
        $display("midframe reset rx_data=%06h dones=%0d", rx_data, dones);

        // Directed table
        for (int i = 0; i < 6; i++) begin
            run_frame(vecs[i].tx, vecs[i].sw, vecs[i].lp, vecs[i].exp_rx, $sformatf("vec%0d", i));
        end

        // Randomised frames against the reference: loopback returns tx, otherwise the slave word.
        for (int i = 0; i < 6; i++) begin
            logic [23:0] rtx, rsw;
            logic        rlp;
            rtx = 24'($urandom);
            rsw = 24'($urandom);
            rlp = 1'($urandom_range(0, 1));
            run_frame(rtx, rsw, rlp, rlp ? rtx : rsw, $sformatf("rnd%0d", i));
        end

        // Start held high: back-to-back frames, cs_n high CS_GAP+1 cycles between them
        wait_idle();
        @(negedge clk_sb);
        loop_en = 1'b1;
        tx_data = 24'h3C3C3C;
        start   = 1'b1;
        n = 0; dones = 0; falls = 0; gap_len = 0;
        pcs = cs_n;
        while (dones < 2 && n < 3000) begin
            @(negedge clk_sb);
            n++;
            if (pcs === 1'b1 && cs_n === 1'b0) falls++;
            pcs = cs_n;
            if (done === 1'b1) dones++;
            if (dones == 1 && cs_n === 1'b1) gap_len++;
        end
        start = 1'b0;
        chk("b2b dones", dones, 2);
        chk("b2b cs_n falls", falls, 2);
        chk("b2b cs_n gap", gap_len, CS_GAP + 1);
        chk("b2b rx_data", {8'd0, rx_data}, 32'h003C3C3C);
        $display("back-to-back frames=%0d gap=%0d", dones, gap_len);

        // Random start pulses while busy create no extra frame
        wait_idle();
        @(negedge clk_sb);
        tx_data = 24'h0F0F0F;
        start   = 1'b1;
        dones = 0; falls = 0;
        pcs = cs_n;
        for (int i = 0; i < 450; i++) begin
            @(negedge clk_sb);
            if (pcs === 1'b1 && cs_n === 1'b0) falls++;
            pcs = cs_n;
            if (done === 1'b1) dones++;
            start = (busy === 1'b1) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        start = 1'b0;
        chk("pulse dones", dones, 1);
        chk("pulse cs_n falls", falls, 1);
        $display("start pulses while busy frames=%0d", dones);

`ifdef SPI_MASTER_BURST_EN
        // Burst: hold_cs=1 then 0, cs_n low across both frames
        begin
            bit sent2 = 0;
            wait_idle();
            @(negedge clk_sb);
            loop_en = 1'b1;
            tx_data = 24'h000001;
            hold_cs = 1'b1;
            start   = 1'b1;
            n = 0; dones = 0; bad = 0;
            while (dones < 2 && n < 3000) begin
                @(negedge clk_sb);
                n++;
                start = 1'b0;
                if (done === 1'b1) begin
                    dones++;
                    if (dones == 1) chk("burst rx1", {8'd0, rx_data}, 32'h00000001);
                end else if (dones == 1 && !sent2 && busy === 1'b0) begin
                    tx_data = 24'h800000;
                    hold_cs = 1'b0;
                    start   = 1'b1;
                    sent2   = 1;
                end
                if (dones < 2 && cs_n === 1'b1) bad++;
            end
            chk("burst dones", dones, 2);
            chk("burst cs_n high", bad, 0);
            chk("burst rises", rise_cnt, 48);
            chk("burst rx2", {8'd0, rx_data}, 32'h00800000);
            chk("burst cs_n end", {31'd0, cs_n}, 32'd1);
            $display("burst frames=%0d rises=%0d", dones, rise_cnt);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
